// File: rtl/snoop_responder.sv
// Snoop side of a 4-line direct-mapped MSI cache: applies bus coherence transitions,
// writes back Modified lines on remote misses and serves local fills and reads.
module snoop_responder #(
    parameter logic [1:0]  CPU_ID = 2'b00,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              bus_valid,
    input  logic [1:0]        bus_src,
    input  logic [1:0]        bus_op,
    input  logic [ADDR_W-1:0] bus_addr,
    output logic              snoop_ready,
    output logic              snoop_done,
    output logic              snoop_hit,
    output logic              abort_mem,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    input  logic              loc_we,
    input  logic [ADDR_W-1:0] loc_addr,
    input  logic [DATA_W-1:0] loc_data,
    input  logic [1:0]        loc_state,
    output logic              loc_stall,
    output logic              loc_rd_hit,
    output logic [1:0]        loc_rd_state,
    output logic [DATA_W-1:0] loc_rd_data
);

    localparam int unsigned LINES = 4;

    localparam logic [1:0] MSI_I = 2'b00;
    localparam logic [1:0] MSI_S = 2'b01;
    localparam logic [1:0] MSI_M = 2'b10;

    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_INV = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WRITEBACK,
        ST_UPDATE
    } fsm_t;

    logic [ADDR_W-1:0] tag_q  [LINES];
    logic [1:0]        st_q   [LINES];
    logic [DATA_W-1:0] data_q [LINES];

    fsm_t              fsm;
    logic [1:0]        src_q;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic              hit_q;

    logic [1:0] snp_idx;
    logic [1:0] loc_idx;
    logic       lookup_hit;

    assign snp_idx = addr_q[2:1];
    assign loc_idx = loc_addr[2:1];

    // Own-bus and no-op messages are walked through the FSM but never hit
    assign lookup_hit = (tag_q[snp_idx] == addr_q) && (st_q[snp_idx] != MSI_I)
                        && (op_q != OP_NOP) && (src_q != CPU_ID);

    assign loc_stall    = loc_we && (fsm != ST_IDLE);
    assign loc_rd_state = st_q[loc_idx];
    assign loc_rd_data  = data_q[loc_idx];
    assign loc_rd_hit   = (tag_q[loc_idx] == loc_addr) && (st_q[loc_idx] != MSI_I);

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int unsigned i = 0; i < LINES; i++) begin
                tag_q[2'(i)]  <= '0;
                st_q[2'(i)]   <= MSI_I;
                data_q[2'(i)] <= '0;
            end
            fsm         <= ST_IDLE;
            src_q       <= '0;
            op_q        <= '0;
            addr_q      <= '0;
            hit_q       <= 1'b0;
            snoop_ready <= 1'b1;
            snoop_done  <= 1'b0;
            snoop_hit   <= 1'b0;
            abort_mem   <= 1'b0;
            wb_valid    <= 1'b0;
            wb_addr     <= '0;
            wb_data     <= '0;
        end else begin
            snoop_done <= 1'b0;
            snoop_hit  <= 1'b0;
            case (fsm)
                ST_IDLE: begin
                    // Local install lands here, so a coincident snoop looks up the new line
                    if (loc_we) begin
                        tag_q[loc_idx]  <= loc_addr;
                        st_q[loc_idx]   <= loc_state;
                        data_q[loc_idx] <= loc_data;
                    end
                    if (bus_valid) begin
                        src_q       <= bus_src;
                        op_q        <= bus_op;
                        addr_q      <= bus_addr;
                        snoop_ready <= 1'b0;
                        fsm         <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    hit_q <= lookup_hit;
                    if (lookup_hit && (st_q[snp_idx] == MSI_M)
                        && ((op_q == OP_RD) || (op_q == OP_WR))) begin
                        abort_mem <= 1'b1;
                        wb_valid  <= 1'b1;
                        wb_addr   <= tag_q[snp_idx];
                        wb_data   <= data_q[snp_idx];
                        fsm       <= ST_WRITEBACK;
                    end else begin
                        fsm <= ST_UPDATE;
                    end
                end
                ST_WRITEBACK: begin
                    if (wb_valid && wb_ready) begin
                        wb_valid <= 1'b0;
                        fsm      <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    // Invalidate of a Modified line drops the data without a write-back
                    if (hit_q) begin
                        case (op_q)
                            OP_RD:         st_q[snp_idx] <= MSI_S;
                            OP_WR, OP_INV: st_q[snp_idx] <= MSI_I;
                            default:       ;
                        endcase
                    end
                    snoop_done  <= 1'b1;
                    snoop_hit   <= hit_q;
                    abort_mem   <= 1'b0;
                    snoop_ready <= 1'b1;
                    fsm         <= ST_IDLE;
                end
                default: fsm <= ST_IDLE;
            endcase
        end
    end

endmodule
